// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel used by the fetch stage.
// The fetch unit is the master: it issues addresses and receives in-order
// instruction words. The memory side uses the slave modport.
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps up to DEPTH requests or
// buffered instructions outstanding, and presents the prefetch-buffer head
// to the F->D register. Redirects from Execute flush the buffer and mark
// every in-flight response as wrong-path so it is dropped on arrival.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallF,
  input  logic                PCSrc_E,
  input  logic [31:0]         PCTarget_E,
  fetch_unit_if.master        imem,
  output logic [31:0]         Instruction_F,
  output logic [31:0]         PC_Out_F,
  output logic [31:0]         PCPlus4_F,
  output logic                Valid_F
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] bufCount_q, bufCount_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] pqWr_q, pqWr_d, pqRd_q, pqRd_d;
  logic [PW-1:0] bufWr_q, bufWr_d, bufRd_q, bufRd_d;

  logic [31:0] pcQueue_q  [DEPTH];
  logic [31:0] bufPc_q    [DEPTH];
  logic [31:0] bufInstr_q [DEPTH];

  logic [CW:0]   creditUsed;
  logic          reqValid;
  logic          accept;
  logic          keepRsp;
  logic          consume;
  logic [31:0]   rspPc;

  // Credit counts both requests in flight and instructions already buffered,
  // so a kept response can never find the buffer full.
  assign creditUsed = {1'b0, inflight_q} + {1'b0, bufCount_q};
  assign reqValid   = !reset && !PCSrc_E && (creditUsed < (CW+1)'(DEPTH));
  assign accept     = reqValid && imem.req_ready;
  assign rspPc      = pcQueue_q[pqRd_q];
  assign keepRsp    = imem.rsp_valid && (discard_q == '0) && !PCSrc_E;
  assign consume    = Valid_F && !StallF;

  assign imem.req_valid = reqValid;
  assign imem.addr      = fetchPc_q;

  assign Valid_F       = (bufCount_q != '0);
  assign Instruction_F = Valid_F ? bufInstr_q[bufRd_q] : NOP;
  assign PC_Out_F      = Valid_F ? bufPc_q[bufRd_q] : 32'h0;
  assign PCPlus4_F     = Valid_F ? (bufPc_q[bufRd_q] + 32'd4) : 32'h0;

  // Next-state for PC, counters and pointers; a redirect overrides the buffer
  // and discard bookkeeping but the PC queue still tracks any response.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem.rsp_valid);
    bufCount_d = bufCount_q;
    discard_d  = discard_q;
    pqWr_d     = pqWr_q;
    pqRd_d     = pqRd_q;
    bufWr_d    = bufWr_q;
    bufRd_d    = bufRd_q;

    if (accept) begin
      fetchPc_d = fetchPc_q + 32'd4;
      pqWr_d    = pqWr_q + PW'(1);
    end
    if (imem.rsp_valid) begin
      pqRd_d = pqRd_q + PW'(1);
    end

    if (PCSrc_E) begin
      fetchPc_d  = PCTarget_E;
      bufCount_d = '0;
      bufWr_d    = '0;
      bufRd_d    = '0;
      // Responses already marked for discard are a subset of those in
      // flight, so every outstanding response (less the one arriving now,
      // which is dropped here) becomes wrong-path.
      discard_d  = inflight_q - CW'(imem.rsp_valid);
    end else begin
      if (imem.rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (keepRsp) begin
        bufWr_d = bufWr_q + PW'(1);
      end
      if (consume) begin
        bufRd_d = bufRd_q + PW'(1);
      end
      bufCount_d = bufCount_q + CW'(keepRsp) - CW'(consume);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      inflight_q <= '0;
      bufCount_q <= '0;
      discard_q  <= '0;
      pqWr_q     <= '0;
      pqRd_q     <= '0;
      bufWr_q    <= '0;
      bufRd_q    <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      inflight_q <= inflight_d;
      bufCount_q <= bufCount_d;
      discard_q  <= discard_d;
      pqWr_q     <= pqWr_d;
      pqRd_q     <= pqRd_d;
      bufWr_q    <= bufWr_d;
      bufRd_q    <= bufRd_d;
    end
  end

  // Storage arrays need no reset: counts and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcQueue_q[pqWr_q] <= fetchPc_q;
    end
    if (keepRsp) begin
      bufPc_q[bufWr_q]    <= rspPc;
      bufInstr_q[bufWr_q] <= imem.rsp_data;
    end
  end

  // Counter invariants: credit never exceeds DEPTH, discards never exceed
  // the responses still owed.
  assert property (@(posedge clk) disable iff (reset)
    creditUsed <= (CW+1)'(DEPTH));
  assert property (@(posedge clk) disable iff (reset)
    discard_q <= inflight_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory
// model (instruction word = its address) and a scoreboard of expected PCs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        PCSrc_E;
  logic [31:0] PCTarget_E;
  logic [31:0] Instruction_F;
  logic [31:0] PC_Out_F;
  logic [31:0] PCPlus4_F;
  logic        Valid_F;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .PCSrc_E       (PCSrc_E),
    .PCTarget_E    (PCTarget_E),
    .imem          (imem),
    .Instruction_F (Instruction_F),
    .PC_Out_F      (PC_Out_F),
    .PCPlus4_F     (PCPlus4_F),
    .Valid_F       (Valid_F)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int memLat = 1;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic restartExpect(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // In-order memory: accepts are queued with a due cycle, one response per
  // cycle is presented once due, and everything is dropped on reset.
  always @(posedge clk) begin
    int      oldCyc;
    memReq_t r;
    oldCyc = cyc;
    if (reset) begin
      memQ.delete();
    end else begin
      if (imem.rsp_valid && memQ.size() > 0) void'(memQ.pop_front());
      if (imem.req_valid && imem.req_ready) begin
        r.addr = imem.addr;
        r.due  = oldCyc + memLat;
        memQ.push_back(r);
      end
    end
    cyc = oldCyc + 1;
    #1;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = memQ[0].addr;
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = 32'h0;
    end
  end

  // Scoreboard: every instruction handed to decode must be the next expected PC.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && !PCSrc_E && Valid_F && !StallF) begin
      check("sbNonEmpty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("headPc", PC_Out_F, e);
        check("headInstr", Instruction_F, e);
        check("headPcPlus4", PCPlus4_F, e + 32'd4);
      end
    end
  end

  initial begin
    logic [31:0] heldAddr;
    logic        found;
    int          rCyc;

    reset = 1'b1; StallF = 1'b0; PCSrc_E = 1'b0; PCTarget_E = 32'h0;
    imem.req_ready = 1'b1;
    memLat = 1;

    // Reset state.
    nextCycle(); nextCycle();
    @(negedge clk);
    check("rstValid", 32'(Valid_F), 32'd0);
    check("rstInstr", Instruction_F, 32'h0000_0013);
    check("rstPc", PC_Out_F, 32'h0);
    check("rstPc4", PCPlus4_F, 32'h0);
    check("rstReqValid", 32'(imem.req_valid), 32'd0);

    // Free-running 1-cycle memory: first request, Valid_F from cycle 2.
    nextCycle(); reset = 1'b0; restartExpect(32'h0);
    @(negedge clk);
    check("c0ReqValid", 32'(imem.req_valid), 32'd1);
    check("c0Addr", imem.addr, 32'h0);
    check("c0Valid", 32'(Valid_F), 32'd0);
    nextCycle(); @(negedge clk);
    check("c1Valid", 32'(Valid_F), 32'd0);
    nextCycle(); @(negedge clk);
    check("c2Valid", 32'(Valid_F), 32'd1);
    check("c2Pc", PC_Out_F, 32'h0);
    nextCycle(); @(negedge clk);
    check("c3Pc", PC_Out_F, 32'h4);

    // Stall with PC 0x8 at the head for 6 cycles.
    nextCycle(); StallF = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nextCycle();
      @(negedge clk);
      check("stallPc", PC_Out_F, 32'h8);
      check("stallInstr", Instruction_F, 32'h8);
    end
    check("stallReqDrop", 32'(imem.req_valid), 32'd0);
    nextCycle(); StallF = 1'b0;
    repeat (8) nextCycle();

    // Memory not ready for 5 cycles: address holds, buffer drains.
    imem.req_ready = 1'b0;
    @(negedge clk);
    heldAddr = imem.addr;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin nextCycle(); @(negedge clk); end
      check("readyLowAddr", imem.addr, heldAddr);
      check("readyLowReqValid", 32'(imem.req_valid), 32'd1);
    end
    check("readyLowDrained", 32'(Valid_F), 32'd0);
    nextCycle(); imem.req_ready = 1'b1;

    // Run on until PC 0x40 is at the head, then pulse reset for one cycle.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      nextCycle(); @(negedge clk);
      if (Valid_F && PC_Out_F == 32'h40) found = 1'b1;
    end
    check("reachPc40", 32'(found), 32'd1);
    nextCycle(); reset = 1'b1; sb.delete();
    nextCycle(); reset = 1'b0; restartExpect(32'h0);
    @(negedge clk);
    check("midRstValid", 32'(Valid_F), 32'd0);
    check("midRstInstr", Instruction_F, 32'h0000_0013);
    check("midRstPc", PC_Out_F, 32'h0);
    check("midRstPc4", PCPlus4_F, 32'h0);
    check("midRstReqValid", 32'(imem.req_valid), 32'd1);
    check("midRstAddr", imem.addr, 32'h0);
    repeat (5) nextCycle();

    // Redirect in the same cycle as a response with one request in flight.
    reset = 1'b1; nextCycle(); reset = 1'b0; restartExpect(32'h0);
    nextCycle();
    PCSrc_E = 1'b1; PCTarget_E = 32'h100; restartExpect(32'h100);
    @(negedge clk);
    check("sameRedirReqLow", 32'(imem.req_valid), 32'd0);
    nextCycle(); PCSrc_E = 1'b0;
    @(negedge clk);
    check("sameRedirAddr", imem.addr, 32'h100);
    check("sameRedirValidR1", 32'(Valid_F), 32'd0);
    nextCycle(); @(negedge clk);
    check("sameRedirValidR2", 32'(Valid_F), 32'd0);
    nextCycle(); @(negedge clk);
    check("sameRedirValidR3", 32'(Valid_F), 32'd1);
    check("sameRedirPc", PC_Out_F, 32'h100);
    repeat (4) nextCycle();

    // 3-cycle memory, two requests in flight, then redirect to 0x100.
    reset = 1'b1; memLat = 3; nextCycle(); reset = 1'b0; restartExpect(32'h0);
    nextCycle(); nextCycle();
    PCSrc_E = 1'b1; PCTarget_E = 32'h100; restartExpect(32'h100);
    @(negedge clk);
    rCyc = cyc;
    check("lat3RedirReqLow", 32'(imem.req_valid), 32'd0);
    nextCycle(); PCSrc_E = 1'b0;
    @(negedge clk);
    check("lat3TargetAddr", imem.addr, 32'h100);
    check("lat3TargetReq", 32'(imem.req_valid), 32'd1);
    found = Valid_F;
    for (int i = 0; i < 12 && !found; i++) begin
      nextCycle(); @(negedge clk);
      found = Valid_F;
    end
    check("lat3ValidSeen", 32'(found), 32'd1);
    check("lat3ValidDelay", 32'(cyc - rCyc), 32'd5);
    check("lat3FirstPc", PC_Out_F, 32'h100);
    repeat (6) nextCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
